multicycle_controller: RTL and testbench

Sequencing FSM for the multicycle RV32I core. It takes the instruction register contents and the memory/compare status, and steps each instruction through FETCH, DECODE, EXEC, MEM and WB. In each state it drives the enables and mux selects for the PC, the IR, the register file, the ALU operand muxes and data memory. The immediate generator and ALU are pure datapath; this block decides when their results are consumed.

---
 rtl/multicycle_controller.sv | 174 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables and mux selects.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [3:0] {
    C_LOAD, C_OPIMM, C_OP, C_JALR, C_STORE, C_BRANCH, C_JAL, C_LUI, C_AUIPC, C_ILLEGAL
  } class_t;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  state_t      state;
  class_t      iclass;
  class_t      decoded;
  logic [15:0] wait_cnt;
  logic        waiting;
  logic        timed_out;
  logic        unused_bits;

  assign unused_bits = ^instruction[31:12];

  always_comb begin
    case (instruction[6:0])
      7'b0000011: decoded = C_LOAD;
      7'b0010011: decoded = C_OPIMM;
      7'b0110011: decoded = C_OP;
      7'b1100111: decoded = C_JALR;
      7'b0100011: decoded = C_STORE;
      7'b1100011: decoded = C_BRANCH;
      7'b1101111: decoded = C_JAL;
      7'b0110111: decoded = C_LUI;
      7'b0010111: decoded = C_AUIPC;
      default:    decoded = C_ILLEGAL;
    endcase
  end

  // A request is outstanding only in FETCH and MEM; timeout fires on the TIMEOUT-th unanswered cycle.
  assign waiting   = (state == FETCH || state == MEM) && !mem_ready;
  assign timed_out = waiting && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      iclass     <= C_ILLEGAL;
      wait_cnt   <= '0;
      trap_cause <= 2'd0;
      instret    <= '0;
    end else begin
      if (pc_we)
        instret <= instret + 32'd1;
      if (waiting)
        wait_cnt <= wait_cnt + 16'd1;
      else
        wait_cnt <= '0;
      case (state)
        FETCH: begin
          if (timed_out) begin
            state      <= TRAP;
            trap_cause <= 2'd2;
          end else if (mem_ready) begin
            state <= DECODE;
          end
        end
        DECODE: begin
          iclass <= decoded;
          if (decoded == C_ILLEGAL) begin
            state      <= TRAP;
            trap_cause <= 2'd1;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (iclass == C_BRANCH)
            state <= FETCH;
          else if (iclass == C_LOAD || iclass == C_STORE)
            state <= MEM;
          else
            state <= WB;
        end
        MEM: begin
          if (timed_out) begin
            state      <= TRAP;
            trap_cause <= 2'd2;
          end else if (mem_ready) begin
            state <= (iclass == C_LOAD) ? WB : FETCH;
          end
        end
        WB:      state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= TRAP;
      endcase
    end
  end

  // Operand selects stay valid through MEM and WB so address and result remain stable while consumed.
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = 2'd0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    trap      = 1'b0;
    if (state == EXEC || state == MEM || state == WB) begin
      case (iclass)
        C_OP:    alu_op = 2'd2;
        C_OPIMM: begin alu_b_sel = 1'b1; alu_op = 2'd2; end
        C_LOAD, C_STORE, C_JALR: alu_b_sel = 1'b1;
        C_AUIPC: begin alu_a_sel = 1'b1; alu_b_sel = 1'b1; end
        C_LUI:   begin alu_b_sel = 1'b1; alu_op = 2'd3; end
        C_BRANCH: alu_op = 2'd1;
        default: ;
      endcase
    end
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        ir_we    = mem_ready;
      end
      EXEC: begin
        if (iclass == C_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? 2'd1 : 2'd0;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (iclass == C_STORE);
        pc_we    = (iclass == C_STORE) && mem_ready;
      end
      WB: begin
        rf_we = (instruction[11:7] != 5'd0);
        pc_we = 1'b1;
        case (iclass)
          C_LOAD:  wb_sel = 2'd1;
          C_JAL:   begin wb_sel = 2'd2; pc_sel = 2'd1; end
          C_JALR:  begin wb_sel = 2'd2; pc_sel = 2'd2; end
          default: ;
        endcase
      end
      TRAP: trap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks instructions cycle by cycle and
// compares the full control vector against hand-derived values.
module tb_multicycle_controller;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        branch_taken;
  logic        imem_req, ir_we, dmem_req, dmem_we, pc_we;
  logic [1:0]  pc_sel;
  logic        alu_a_sel, alu_b_sel;
  logic [1:0]  alu_op;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;
  logic [16:0] ctl_vec;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] BEQ   = 32'h00000463;
  localparam logic [31:0] LW    = 32'h00002103;
  localparam logic [31:0] SW    = 32'h00202023;
  localparam logic [31:0] JAL0  = 32'h0000006F;
  localparam logic [31:0] JALR1 = 32'h000000E7;
  localparam logic [31:0] LUI3  = 32'h000011B7;
  localparam logic [31:0] ADD4  = 32'h00208233;
  localparam logic [31:0] AUIPC = 32'h00000297;
  localparam logic [31:0] ILL   = 32'h0000007F;

  multicycle_controller #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .imem_req(imem_req), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .rf_we(rf_we),
    .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  assign ctl_vec = {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, alu_a_sel,
                    alu_b_sel, alu_op, rf_we, wb_sel, trap, trap_cause};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [16:0] ctl(input logic imem, input logic ir, input logic dreq,
                                      input logic dwe, input logic pcwe, input logic [1:0] pcsel,
                                      input logic asel, input logic bsel, input logic [1:0] op,
                                      input logic rfwe, input logic [1:0] wbsel, input logic trp,
                                      input logic [1:0] cause);
    return {imem, ir, dreq, dwe, pcwe, pcsel, asel, bsel, op, rfwe, wbsel, trp, cause};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge: drive one cycle's inputs, sample, then advance to the next falling edge.
  task automatic applyStimulus(input string tag, input logic [31:0] instr, input logic ready,
                               input logic taken, input logic [16:0] expv);
    instruction  = instr;
    mem_ready    = ready;
    branch_taken = taken;
    #1;
    checkOutput(tag, {15'b0, ctl_vec}, {15'b0, expv});
    @(negedge clk);
  endtask

  task automatic applyReset(input string tag);
    rst_n        = 1'b0;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;
    #1;
    checkOutput({tag, "_ctl"}, {15'b0, ctl_vec}, {15'b0, ctl(1,0,0,0,0,0,0,0,0,0,0,0,0)});
    checkOutput({tag, "_instret"}, instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [16:0] fetch_hit, fetch_wait, idle;
    fetch_hit  = ctl(1,1,0,0,0,0,0,0,0,0,0,0,0);
    fetch_wait = ctl(1,0,0,0,0,0,0,0,0,0,0,0,0);
    idle       = '0;
    instruction  = ADDI;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;
    rst_n        = 1'b1;
    #1;
    applyReset("reset0");

    applyStimulus("addi_fetch",  ADDI, 1, 0, fetch_hit);
    applyStimulus("addi_decode", ADDI, 1, 0, idle);
    applyStimulus("addi_exec",   ADDI, 1, 0, ctl(0,0,0,0,0,0,0,1,2,0,0,0,0));
    applyStimulus("addi_wb",     ADDI, 1, 0, ctl(0,0,0,0,1,0,0,1,2,1,0,0,0));
    checkOutput("addi_instret", instret, 32'd1);

    applyStimulus("beqt_fetch",  BEQ, 1, 1, fetch_hit);
    applyStimulus("beqt_decode", BEQ, 1, 1, idle);
    applyStimulus("beqt_exec",   BEQ, 1, 1, ctl(0,0,0,0,1,1,0,0,1,0,0,0,0));
    checkOutput("beqt_instret", instret, 32'd2);
    applyStimulus("beqn_fetch",  BEQ, 1, 0, fetch_hit);
    applyStimulus("beqn_decode", BEQ, 1, 0, idle);
    applyStimulus("beqn_exec",   BEQ, 1, 0, ctl(0,0,0,0,1,0,0,0,1,0,0,0,0));
    checkOutput("beqn_instret", instret, 32'd3);

    for (int i = 0; i < 2; i++) applyStimulus("lw_fetch_wait", LW, 0, 0, fetch_wait);
    applyStimulus("lw_fetch",  LW, 1, 0, fetch_hit);
    applyStimulus("lw_decode", LW, 1, 0, idle);
    applyStimulus("lw_exec",   LW, 1, 0, ctl(0,0,0,0,0,0,0,1,0,0,0,0,0));
    for (int i = 0; i < 3; i++) applyStimulus("lw_mem_wait", LW, 0, 0, ctl(0,0,1,0,0,0,0,1,0,0,0,0,0));
    applyStimulus("lw_mem_done", LW, 1, 0, ctl(0,0,1,0,0,0,0,1,0,0,0,0,0));
    applyStimulus("lw_wb",       LW, 1, 0, ctl(0,0,0,0,1,0,0,1,0,1,1,0,0));
    checkOutput("lw_instret", instret, 32'd4);

    applyStimulus("sw_fetch",  SW, 1, 0, fetch_hit);
    applyStimulus("sw_decode", SW, 1, 0, idle);
    applyStimulus("sw_exec",   SW, 1, 0, ctl(0,0,0,0,0,0,0,1,0,0,0,0,0));
    applyStimulus("sw_mem",    SW, 1, 0, ctl(0,0,1,1,1,0,0,1,0,0,0,0,0));
    checkOutput("sw_instret", instret, 32'd5);

    applyStimulus("jal_fetch",  JAL0, 1, 0, fetch_hit);
    applyStimulus("jal_decode", JAL0, 1, 0, idle);
    applyStimulus("jal_exec",   JAL0, 1, 0, idle);
    applyStimulus("jal_wb",     JAL0, 1, 0, ctl(0,0,0,0,1,1,0,0,0,0,2,0,0));
    applyStimulus("jalr_fetch",  JALR1, 1, 0, fetch_hit);
    applyStimulus("jalr_decode", JALR1, 1, 0, idle);
    applyStimulus("jalr_exec",   JALR1, 1, 0, ctl(0,0,0,0,0,0,0,1,0,0,0,0,0));
    applyStimulus("jalr_wb",     JALR1, 1, 0, ctl(0,0,0,0,1,2,0,1,0,1,2,0,0));
    checkOutput("jalr_instret", instret, 32'd7);

    applyStimulus("lui_fetch",  LUI3, 1, 0, fetch_hit);
    applyStimulus("lui_decode", LUI3, 1, 0, idle);
    applyStimulus("lui_exec",   LUI3, 1, 0, ctl(0,0,0,0,0,0,0,1,3,0,0,0,0));
    applyStimulus("lui_wb",     LUI3, 1, 0, ctl(0,0,0,0,1,0,0,1,3,1,0,0,0));
    applyStimulus("add_fetch",  ADD4, 1, 0, fetch_hit);
    applyStimulus("add_decode", ADD4, 1, 0, idle);
    applyStimulus("add_exec",   ADD4, 1, 0, ctl(0,0,0,0,0,0,0,0,2,0,0,0,0));
    applyStimulus("add_wb",     ADD4, 1, 0, ctl(0,0,0,0,1,0,0,0,2,1,0,0,0));
    applyStimulus("auipc_fetch",  AUIPC, 1, 0, fetch_hit);
    applyStimulus("auipc_decode", AUIPC, 1, 0, idle);
    applyStimulus("auipc_exec",   AUIPC, 1, 0, ctl(0,0,0,0,0,0,1,1,0,0,0,0,0));
    applyStimulus("auipc_wb",     AUIPC, 1, 0, ctl(0,0,0,0,1,0,1,1,0,1,0,0,0));
    checkOutput("auipc_instret", instret, 32'd10);

    applyStimulus("ill_fetch",  ILL, 1, 0, fetch_hit);
    applyStimulus("ill_decode", ILL, 1, 0, idle);
    for (int i = 0; i < 10; i++)
      applyStimulus("ill_trap", ILL, logic'(i % 2), 0, ctl(0,0,0,0,0,0,0,0,0,0,0,1,1));
    checkOutput("ill_instret", instret, 32'd10);
    applyReset("reset_after_ill");

    for (int i = 0; i < 4; i++) applyStimulus("to_fetch_wait", ADDI, 0, 0, fetch_wait);
    for (int i = 0; i < 2; i++) applyStimulus("to_fetch_trap", ADDI, 1, 0, ctl(0,0,0,0,0,0,0,0,0,0,0,1,2));
    applyReset("reset_after_timeout");

    for (int i = 0; i < 3; i++) applyStimulus("edge_fetch_wait", ADDI, 0, 0, fetch_wait);
    applyStimulus("edge_fetch",  ADDI, 1, 0, fetch_hit);
    applyStimulus("edge_decode", ADDI, 1, 0, idle);
    applyStimulus("edge_exec",   ADDI, 1, 0, ctl(0,0,0,0,0,0,0,1,2,0,0,0,0));
    applyStimulus("edge_wb",     ADDI, 1, 0, ctl(0,0,0,0,1,0,0,1,2,1,0,0,0));
    checkOutput("edge_instret", instret, 32'd1);

    applyStimulus("memto_fetch",  LW, 1, 0, fetch_hit);
    applyStimulus("memto_decode", LW, 1, 0, idle);
    applyStimulus("memto_exec",   LW, 1, 0, ctl(0,0,0,0,0,0,0,1,0,0,0,0,0));
    for (int i = 0; i < 4; i++) applyStimulus("memto_wait", LW, 0, 0, ctl(0,0,1,0,0,0,0,1,0,0,0,0,0));
    for (int i = 0; i < 2; i++) applyStimulus("memto_trap", LW, 1, 0, ctl(0,0,0,0,0,0,0,0,0,0,0,1,2));
    checkOutput("memto_instret", instret, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
